// File: rtl/dec_pkg.sv
//------------------------------------------------------------------------------
// dec_pkg : shared sizing, state encoding and Busy mapping for enc16to4_seq.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dec_pkg;

  localparam int N     = 16;
  localparam int IDX_W = 4;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EMIT = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  function automatic logic busy_of(input logic [1:0] st);
    return (st == EMIT) || (st == DONE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/prio_enc16.sv
//------------------------------------------------------------------------------
// prio_enc16 : combinational lowest-set-bit encoder; any=0 when no bit is set.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prio_enc16 #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [0:N-1]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/enc16to4_seq.sv
//------------------------------------------------------------------------------
// enc16to4_seq : captures a multi-hot request vector and serializes the index
// of every set line, lowest first, over a valid/ready handshake.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module enc16to4_seq
  import dec_pkg::*;
#(
  parameter int N     = dec_pkg::N,
  parameter int IDX_W = dec_pkg::IDX_W
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             En,
  input  logic             Load,
  input  logic [0:N-1]     W,
  output logic [IDX_W-1:0] Y,
  output logic             Valid,
  input  logic             Ready,
  output logic             Busy,
  output logic             Zero,
  output logic             Done,
  output logic [IDX_W:0]   Count
);

  logic [1:0]       state_q, state_d;
  logic [0:N-1]     pend_q, pend_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             zero_q, zero_d;

  logic [IDX_W-1:0] pend_idx;
  logic             pend_any_unused;
  logic [IDX_W-1:0] req_idx_unused;
  logic             req_any;

  prio_enc16 #(.N(N), .IDX_W(IDX_W)) u_pend_enc (
    .req (pend_q),
    .idx (pend_idx),
    .any (pend_any_unused)
  );

  prio_enc16 #(.N(N), .IDX_W(IDX_W)) u_req_enc (
    .req (W),
    .idx (req_idx_unused),
    .any (req_any)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    count_d = count_q;
    zero_d  = zero_q;
    if (En) begin
      case (state_q)
        IDLE: begin
          if (Load) begin
            pend_d  = W;
            count_d = '0;
            zero_d  = ~req_any;
            state_d = req_any ? EMIT : DONE;
          end
        end
        EMIT: begin
          if (Ready) begin
            pend_d[pend_idx] = 1'b0;
            count_d          = count_q + (IDX_W + 1)'(1);
            if (pend_d == '0) begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      pend_q  <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  // Y is forced to 0 whenever no index is being offered.
  assign Valid = En && (state_q == EMIT);
  assign Y     = Valid ? pend_idx : '0;
  assign Done  = En && (state_q == DONE);
  assign Busy  = busy_of(state_q);
  assign Zero  = zero_q;
  assign Count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_enc16to4_seq.sv
//------------------------------------------------------------------------------
// tb_enc16to4_seq : scoreboard bench for enc16to4_seq with a loopback decode.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_enc16to4_seq;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        En;
  logic        Load;
  logic [0:15] W;
  logic [3:0]  Y;
  logic        Valid;
  logic        Ready;
  logic        Busy;
  logic        Zero;
  logic        Done;
  logic [4:0]  Count;

  enc16to4_seq dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .En    (En),
    .Load  (Load),
    .W     (W),
    .Y     (Y),
    .Valid (Valid),
    .Ready (Ready),
    .Busy  (Busy),
    .Zero  (Zero),
    .Done  (Done),
    .Count (Count)
  );

  always #5 Clock = ~Clock;

  int          errors = 0;
  int          checks = 0;
  int          exp_q[$];
  logic [0:15] cap_w   = '0;
  int          exp_cnt = 0;
  int          done_seen = 0;
  int          ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes the expected index stream and rebuilds the vector
  // through a behavioural one-hot decode of each accepted index.
  logic [0:15] acc = '0;
  int          xfers = 0;
  logic        prev_stall = 1'b0;
  logic [3:0]  prev_y = '0;

  always @(negedge Clock) begin
    if (!Resetn) begin
      acc        = '0;
      xfers      = 0;
      prev_stall = 1'b0;
    end else begin
      if (!Valid) chk("y_gated", 32'(Y), 0);
      if (prev_stall && Valid) chk("y_stable", 32'(Y), 32'(prev_y));
      if (Valid && Ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got Y=%0d expected no transfer", Y);
        end else begin
          chk("y_order", 32'(Y), 32'(exp_q.pop_front()));
        end
        chk("count_run", 32'(Count), 32'(xfers));
        xfers++;
        acc[Y] = 1'b1;
      end
      prev_stall = Valid && !Ready;
      prev_y     = Y;
      if (Done) begin
        chk("done_pending", 32'(exp_q.size()), 0);
        chk("loopback", 32'(acc), 32'(cap_w));
        chk("count_final", 32'(Count), 32'(exp_cnt));
        chk("zero_flag", 32'(Zero), 32'(cap_w == 16'h0));
        done_seen++;
        acc   = '0;
        xfers = 0;
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Reference: every set line, ascending index order.
  task automatic load(input logic [0:15] w);
    cap_w   = w;
    exp_cnt = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (w[i]) begin
        exp_q.push_back(i);
        exp_cnt++;
      end
    end
    En   = 1'b1;
    Load = 1'b1;
    W    = w;
    tick();
    Load = 1'b0;
    W    = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int start = done_seen;
    bit hit = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done_seen > start) begin
        hit = 1'b1;
        break;
      end
      case (ready_mode)
        1:       Ready = ~Ready;
        2: begin
          Ready = 1'($urandom);
          En    = ($urandom % 5) != 0;
        end
        default: Ready = 1'b1;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no Done in %0d cycles expected a pulse", budget);
    end
    En = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:15] w;
    int          d0;
    Resetn = 1'b0;
    En     = 1'b0;
    Load   = 1'b0;
    Ready  = 1'b0;
    W      = '0;
    tick();
    tick();
    chk("rst_valid", 32'(Valid), 0);
    chk("rst_y", 32'(Y), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_zero", 32'(Zero), 0);
    chk("rst_count", 32'(Count), 0);
    Resetn = 1'b1;
    tick();

    // Lines 0 and 15.
    Ready = 1'b1;
    load(16'b1000_0000_0000_0001);
    chk("t1_valid_k1", 32'(Valid), 1);
    chk("t1_y_k1", 32'(Y), 0);
    chk("t1_busy", 32'(Busy), 1);
    tick();
    chk("t1_valid_k2", 32'(Valid), 1);
    chk("t1_y_k2", 32'(Y), 15);
    tick();
    chk("t1_done_k3", 32'(Done), 1);
    chk("t1_valid_k3", 32'(Valid), 0);
    chk("t1_count", 32'(Count), 2);
    chk("t1_zero", 32'(Zero), 0);
    tick();
    chk("t1_done_off", 32'(Done), 0);
    chk("t1_busy_off", 32'(Busy), 0);

    // Empty vector.
    load(16'h0000);
    chk("t2_valid", 32'(Valid), 0);
    chk("t2_done", 32'(Done), 1);
    chk("t2_busy", 32'(Busy), 1);
    chk("t2_zero", 32'(Zero), 1);
    tick();
    chk("t2_done_off", 32'(Done), 0);
    chk("t2_busy_off", 32'(Busy), 0);
    chk("t2_zero_held", 32'(Zero), 1);

    // All lines with Ready toggling.
    d0         = done_seen;
    ready_mode = 1;
    Ready      = 1'b1;
    load(16'hFFFF);
    wait_done(100);
    tick();
    tick();
    chk("t3_single_done", 32'(done_seen - d0), 1);
    chk("t3_count", 32'(Count), 16);

    // Lines 8..11 with an enable dropout after the first transfer.
    ready_mode = 0;
    Ready      = 1'b1;
    load(16'h00F0);
    chk("t4_y_first", 32'(Y), 8);
    tick();
    En = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("t4_valid_frozen", 32'(Valid), 0);
      chk("t4_count_frozen", 32'(Count), 1);
      tick();
    end
    En   = 1'b1;
    Load = 1'b1;
    W    = 16'hFFFF;
    #1;
    chk("t4_y_resume", 32'(Y), 9);
    wait_done(50);
    Load = 1'b0;

    // Reset in the middle of emission.
    load(16'b0100_1010_0000_1010);
    tick();
    tick();
    chk("t5_y_before_rst", 32'(Y), 6);
    Resetn = 1'b0;
    #1;
    exp_q.delete();
    chk("t5_rst_valid", 32'(Valid), 0);
    chk("t5_rst_y", 32'(Y), 0);
    chk("t5_rst_busy", 32'(Busy), 0);
    chk("t5_rst_count", 32'(Count), 0);
    tick();
    Resetn = 1'b1;
    tick();
    chk("t5_idle", 32'(Busy), 0);
    load(16'b0001_0000_0000_0000);
    chk("t5_y3", 32'(Y), 3);
    wait_done(20);

    // Random vectors with random Ready and enable dropouts.
    ready_mode = 2;
    for (int t = 0; t < 24; t++) begin
      case (t % 8)
        0:       w = 16'h0000;
        1:       w = 16'h0001;
        default: w = 16'($urandom);
      endcase
      Ready = 1'($urandom);
      load(w);
      wait_done(400);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
